// File: rtl/score_keeper.sv
// score_keeper: fixed-priority award arbiter with a digit-serial BCD adder that
// commits a shadow score atomically. Define HIGH_SCORE_EN to add a high-score register.
module score_keeper #(
  parameter logic [19:0] PELLET_PTS = 20'h00010,
  parameter logic [19:0] POWER_PTS  = 20'h00050,
  parameter logic [19:0] GHOST_PTS  = 20'h00200,
  parameter logic [19:0] FRUIT_PTS  = 20'h00100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score_clear,
  input  logic       pellet_req,
  input  logic       power_req,
  input  logic       ghost_req,
  input  logic       fruit_req,
  output logic       pellet_ack,
  output logic       power_ack,
  output logic       ghost_ack,
  output logic       fruit_ack,
  output logic       busy,
  output logic [3:0] digit_zero,
  output logic [3:0] digit_one,
  output logic [3:0] digit_two,
  output logic [3:0] digit_three,
  output logic [3:0] digit_four,
  output logic       extra_life,
  output logic [3:0] hi_digit_zero,
  output logic [3:0] hi_digit_one,
  output logic [3:0] hi_digit_two,
  output logic [3:0] hi_digit_three,
  output logic [3:0] hi_digit_four
);

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, ADD4, COMMIT} state_t;

  state_t      state, state_next;

  // Packed BCD: [19:16] is ten-thousands, [3:0] is ones, so numeric order
  // matches unsigned vector order.
  logic [19:0] score;
  logic [19:0] shadow;
  logic [19:0] addend;
  logic        carry;
  logic [3:0]  ack_q;        // {ghost, fruit, power, pellet}
  logic        extra_life_q;

  logic        any_req;
  logic [3:0]  grant_vec;
  logic [19:0] grant_pts;
  logic [2:0]  add_idx;
  logic [3:0]  sh_dig;
  logic [3:0]  ad_dig;
  logic [4:0]  dig_sum;
  logic [3:0]  dig_res;
  logic        carry_next;
  logic [19:0] commit_val;

  assign any_req = ghost_req | fruit_req | power_req | pellet_req;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant_vec = 4'b0000;
    grant_pts = PELLET_PTS;
    if (ghost_req) begin
      grant_vec = 4'b1000;
      grant_pts = GHOST_PTS;
    end else if (fruit_req) begin
      grant_vec = 4'b0100;
      grant_pts = FRUIT_PTS;
    end else if (power_req) begin
      grant_vec = 4'b0010;
      grant_pts = POWER_PTS;
    end else if (pellet_req) begin
      grant_vec = 4'b0001;
      grant_pts = PELLET_PTS;
    end
  end

  always_comb begin
    state_next = state;
    if (score_clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (any_req) state_next = ADD0;
        ADD0:    state_next = ADD1;
        ADD1:    state_next = ADD2;
        ADD2:    state_next = ADD3;
        ADD3:    state_next = ADD4;
        ADD4:    state_next = COMMIT;
        COMMIT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // One BCD digit per ADD state, ones digit first.
  always_comb begin
    add_idx = 3'd0;
    case (state)
      ADD1:    add_idx = 3'd1;
      ADD2:    add_idx = 3'd2;
      ADD3:    add_idx = 3'd3;
      ADD4:    add_idx = 3'd4;
      default: add_idx = 3'd0;
    endcase
    sh_dig     = shadow[{add_idx, 2'b00} +: 4];
    ad_dig     = addend[{add_idx, 2'b00} +: 4];
    dig_sum    = {1'b0, sh_dig} + {1'b0, ad_dig} + {4'b0000, carry};
    dig_res    = dig_sum[3:0];
    carry_next = 1'b0;
    if (dig_sum > 5'd9) begin
      dig_res    = dig_sum[3:0] - 4'd10;
      carry_next = 1'b1;
    end
    commit_val = carry ? 20'h99999 : shadow;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || score_clear) begin
      score        <= '0;
      shadow       <= '0;
      addend       <= '0;
      carry        <= 1'b0;
      ack_q        <= '0;
      extra_life_q <= 1'b0;
    end else begin
      ack_q        <= '0;
      extra_life_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ack_q  <= grant_vec;
            addend <= grant_pts;
            shadow <= score;
            carry  <= 1'b0;
          end
        end
        ADD0, ADD1, ADD2, ADD3, ADD4: begin
          shadow[{add_idx, 2'b00} +: 4] <= dig_res;
          carry                         <= carry_next;
        end
        COMMIT: begin
          score        <= commit_val;
          extra_life_q <= (score[19:16] == 4'd0) && (commit_val[19:16] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // Outputs are masked while clear is asserted so nothing is signalled in the
  // clearing cycle itself.
  assign ghost_ack  = ack_q[3] & ~score_clear;
  assign fruit_ack  = ack_q[2] & ~score_clear;
  assign power_ack  = ack_q[1] & ~score_clear;
  assign pellet_ack = ack_q[0] & ~score_clear;
  assign extra_life = extra_life_q & ~score_clear;
  assign busy       = (state != IDLE);

  assign digit_zero  = score[19:16];
  assign digit_one   = score[15:12];
  assign digit_two   = score[11:8];
  assign digit_three = score[7:4];
  assign digit_four  = score[3:0];

`ifdef HIGH_SCORE_EN
  logic [19:0] hi_score;

  // Survives score_clear; only reset returns it to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_score <= '0;
    end else if (!score_clear && state == COMMIT && commit_val > hi_score) begin
      hi_score <= commit_val;
    end
  end

  assign hi_digit_zero  = hi_score[19:16];
  assign hi_digit_one   = hi_score[15:12];
  assign hi_digit_two   = hi_score[11:8];
  assign hi_digit_three = hi_score[7:4];
  assign hi_digit_four  = hi_score[3:0];
`else
  assign hi_digit_zero  = 4'd0;
  assign hi_digit_one   = 4'd0;
  assign hi_digit_two   = 4'd0;
  assign hi_digit_three = 4'd0;
  assign hi_digit_four  = 4'd0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random request
// mixes, checked against a decimal-arithmetic reference model.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       score_clear;
  logic [3:0] req;          // {ghost, fruit, power, pellet}
  logic       pellet_ack, power_ack, ghost_ack, fruit_ack;
  logic       busy, extra_life;
  logic [3:0] d0, d1, d2, d3, d4;
  logic [3:0] h0, h1, h2, h3, h4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain decimal integers.
  int model_score = 0;
  int model_hi    = 0;
  bit exp_xl      = 1'b0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .reset(reset), .score_clear(score_clear),
    .pellet_req(req[0]), .power_req(req[1]), .ghost_req(req[3]), .fruit_req(req[2]),
    .pellet_ack(pellet_ack), .power_ack(power_ack), .ghost_ack(ghost_ack), .fruit_ack(fruit_ack),
    .busy(busy),
    .digit_zero(d0), .digit_one(d1), .digit_two(d2), .digit_three(d3), .digit_four(d4),
    .extra_life(extra_life),
    .hi_digit_zero(h0), .hi_digit_one(h1), .hi_digit_two(h2), .hi_digit_three(h3),
    .hi_digit_four(h4)
  );

  wire [3:0]  acks   = {ghost_ack, fruit_ack, power_ack, pellet_ack};
  wire [19:0] digits = {d0, d1, d2, d3, d4};
  wire [19:0] hi     = {h0, h1, h2, h3, h4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pts_of(input int src);
    case (src)
      0:       return 10;
      1:       return 50;
      2:       return 100;
      default: return 200;
    endcase
  endfunction

  function automatic void model_apply(input int src);
    int n;
    n = model_score + pts_of(src);
    if (n > 99999) n = 99999;
    exp_xl = (model_score < 10000) && (n >= 10000);
    model_score = n;
`ifdef HIGH_SCORE_EN
    if (n > model_hi) model_hi = n;
`endif
  endfunction

  // Raise every request in mask, hold each until acked, and check the whole
  // grant/add/commit sequence for each award in priority order.
  task automatic run_batch(input logic [3:0] mask);
    logic [3:0]  pend;
    logic [3:0]  exp_ack;
    logic [31:0] old;
    int          w;
    pend = mask;
    req  = mask;
    while (pend != 4'b0000) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (pend[i]) w = i;
      exp_ack = 4'b0001 << w;
      old = to_bcd(model_score);
      tick();
      check("ack", acks, exp_ack);
      check("busy_at_ack", busy, 1);
      check("xl_at_ack", extra_life, 0);
      pend[w] = 1'b0;
      req     = pend;
      model_apply(w);
      for (int c = 0; c < 5; c++) begin
        tick();
        check("busy_mid", busy, 1);
        check("digits_hold", digits, old);
        check("ack_once", acks, 0);
      end
      tick();
      check("busy_done", busy, 0);
      check("digits_new", digits, to_bcd(model_score));
      check("extra_life", extra_life, exp_xl);
      check("hi", hi, to_bcd(model_hi));
    end
  endtask

  task automatic reach(input int target);
    while (model_score < target) begin
      if (target - model_score >= 200)      run_batch(4'b1000);
      else if (target - model_score >= 100) run_batch(4'b0100);
      else if (target - model_score >= 50)  run_batch(4'b0010);
      else                                  run_batch(4'b0001);
    end
  endtask

  task automatic do_clear();
    score_clear = 1'b1;
    tick();
    check("clr_digits", digits, 0);
    check("clr_busy", busy, 0);
    check("clr_hi", hi, to_bcd(model_hi));
    score_clear = 1'b0;
    model_score = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_score = 0;
    model_hi    = 0;
    check("rst_busy", busy, 0);
    check("rst_acks", acks, 0);
    check("rst_xl", extra_life, 0);
    check("rst_digits", digits, 0);
    check("rst_hi", hi, 0);
  endtask

  initial begin
    reset       = 1'b1;
    score_clear = 1'b0;
    req         = 4'b0000;

    // Reset values.
    do_reset();

    // Single pellet.
    run_batch(4'b0001);
    check("pellet_score", digits, 20'h00010);

    // Three simultaneous requests: ghost, power, pellet.
    do_clear();
    run_batch(4'b1011);
    check("batch_score", digits, 20'h00260);

    // High score survives clear.
    reach(300);
    do_clear();
    reach(100);
`ifdef HIGH_SCORE_EN
    check("hi_kept", hi, 20'h00300);
`else
    check("hi_tied", hi, 20'h00000);
`endif

    // Random request mixes.
    for (int r = 0; r < 20; r++) begin
      run_batch(4'($urandom_range(1, 15)));
    end

    // Extra life on first crossing of 10000, not again.
    do_clear();
    reach(9990);
    run_batch(4'b1000);
    check("cross_digits", digits, 20'h10190);
    check("cross_xl", extra_life, 1);
    tick();
    check("xl_one_cycle", extra_life, 0);
    run_batch(4'b0001);
    check("no_second_xl", extra_life, 0);

    // Saturation at 99999.
    reach(99950);
    run_batch(4'b1000);
    check("saturate", digits, 20'h99999);
    run_batch(4'b0001);
    check("saturate_hold", digits, 20'h99999);

    // Clear during ADD2 with fruit acked; pellet waits until clear drops.
    req = 4'b0100;
    tick();
    check("fruit_ack", acks, 4'b0100);
    req = 4'b0000;
    tick();
    tick();
    score_clear = 1'b1;
    req         = 4'b0001;
    check("clr_mask_ack", acks, 0);
    tick();
    check("mid_clr_busy", busy, 0);
    check("mid_clr_digits", digits, 0);
    check("mid_clr_acks", acks, 0);
    check("mid_clr_xl", extra_life, 0);
    tick();
    check("clr_no_grant", acks, 0);
    check("clr_idle", busy, 0);
    score_clear = 1'b0;
    model_score = 0;
    run_batch(4'b0001);
    check("after_clr", digits, 20'h00010);

    // Reset clears the high score too.
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
